// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between two masters, serializing their single-cycle strobes.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  input  logic                m0_rstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_busy,
  output logic                m0_done,
  output logic                m0_err,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  input  logic                m1_rstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_busy,
  output logic                m1_done,
  output logic                m1_err,
  output logic [ADDR_W-1:0]   down_addr,
  output logic [DATA_W-1:0]   down_wdata,
  output logic [DATA_W/8-1:0] down_wmask,
  output logic                down_rstrb,
  input  logic [DATA_W-1:0]   down_rdata,
  input  logic                down_rbusy
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   grant_vld;
  logic   grant_id;

  logic [1:0]        req_rstrb;
  logic [MASK_W-1:0] req_wmask [2];
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];

  logic [1:0]        slot_valid_q, slot_valid_d;
  logic [1:0]        slot_wr_q, slot_wr_d;
  logic [ADDR_W-1:0] slot_addr_d  [2];
  logic [DATA_W-1:0] slot_wdata_d [2];
  logic [MASK_W-1:0] slot_wmask_d [2];
  logic [1:0]        complete;
  logic [1:0]        req_done;
  logic [1:0]        req_err;
  logic [DATA_W-1:0] req_rdata [2];

  logic [ADDR_W-1:0] down_addr_q, down_addr_d;
  logic [DATA_W-1:0] down_wdata_q, down_wdata_d;
  logic [MASK_W-1:0] down_wmask_q, down_wmask_d;
  logic              down_rstrb_q, down_rstrb_d;

  assign req_rstrb    = {m1_rstrb, m0_rstrb};
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;

  // The owner's transaction finishes in ISSUE for writes, or on the first non-stalled WAIT cycle for reads.
  always_comb begin
    complete = 2'b00;
    if (state_q == ISSUE && slot_wr_q[owner_q]) begin
      complete[owner_q] = 1'b1;
    end
    if (state_q == WAIT && !down_rbusy) begin
      complete[owner_q] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic              valid_q, valid_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              err_q, err_d;
    logic              done_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              strobe;

    always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      strobe  = req_rstrb[gi] | (|req_wmask[gi]);
      if (complete[gi]) begin
        valid_d = 1'b0;
        if (!wr_q) begin
          rdata_d = down_rdata;
        end
      end
      // A strobe against an occupied slot is dropped; the slot can never complete and load in one cycle.
      if (strobe) begin
        if (valid_q) begin
          err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          wr_d    = |req_wmask[gi];
          addr_d  = req_addr[gi];
          wdata_d = req_wdata[gi];
          wmask_d = req_wmask[gi];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        wr_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        wmask_q <= '0;
        err_q   <= 1'b0;
        done_q  <= 1'b0;
        rdata_q <= '0;
      end else begin
        valid_q <= valid_d;
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        err_q   <= err_d;
        done_q  <= complete[gi];
        rdata_q <= rdata_d;
      end
    end

    assign slot_valid_q[gi] = valid_q;
    assign slot_valid_d[gi] = valid_d;
    assign slot_wr_q[gi]    = wr_q;
    assign slot_wr_d[gi]    = wr_d;
    assign slot_addr_d[gi]  = addr_d;
    assign slot_wdata_d[gi] = wdata_d;
    assign slot_wmask_d[gi] = wmask_d;
    assign req_done[gi]     = done_q;
    assign req_err[gi]      = err_q;
    assign req_rdata[gi]    = rdata_q;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (&slot_valid_d) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~slot_valid_d[0];
    end
    last_grant_d = grant_vld ? grant_id : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_id = ~slot_valid_d[0];
`endif

  // Arbitrating on the next-cycle slot view lets a fresh strobe issue immediately and keeps writes back-to-back.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant_vld = 1'b0;
    case (state_q)
      IDLE: begin
        grant_vld = |slot_valid_d;
      end
      ISSUE: begin
        if (slot_wr_q[owner_q]) begin
          grant_vld = |slot_valid_d;
          state_d   = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!down_rbusy) begin
          grant_vld = |slot_valid_d;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (grant_vld) begin
      state_d = ISSUE;
      owner_d = grant_id;
    end
  end

  always_comb begin
    down_addr_d  = down_addr_q;
    down_wdata_d = down_wdata_q;
    down_wmask_d = '0;
    down_rstrb_d = 1'b0;
    if (grant_vld) begin
      down_addr_d  = slot_addr_d[grant_id];
      down_wdata_d = slot_wdata_d[grant_id];
      if (slot_wr_d[grant_id]) begin
        down_wmask_d = slot_wmask_d[grant_id];
      end else begin
        down_rstrb_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      down_addr_q  <= '0;
      down_wdata_q <= '0;
      down_wmask_q <= '0;
      down_rstrb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      down_addr_q  <= down_addr_d;
      down_wdata_q <= down_wdata_d;
      down_wmask_q <= down_wmask_d;
      down_rstrb_q <= down_rstrb_d;
    end
  end

  assign m0_rdata   = req_rdata[0];
  assign m1_rdata   = req_rdata[1];
  assign m0_busy    = slot_valid_q[0];
  assign m1_busy    = slot_valid_q[1];
  assign m0_done    = req_done[0];
  assign m1_done    = req_done[1];
  assign m0_err     = req_err[0];
  assign m1_err     = req_err[1];
  assign down_addr  = down_addr_q;
  assign down_wdata = down_wdata_q;
  assign down_wmask = down_wmask_q;
  assign down_rstrb = down_rstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter, plus hand sequences for
// protocol violation, simultaneous requests, reset mid-read and back-to-back writes.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [MASK_W-1:0] m0_wmask, m1_wmask;
  logic              m0_rstrb, m1_rstrb;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_busy, m1_busy, m0_done, m1_done, m0_err, m1_err;
  logic [ADDR_W-1:0] down_addr;
  logic [DATA_W-1:0] down_wdata;
  logic [MASK_W-1:0] down_wmask;
  logic              down_rstrb;
  logic [DATA_W-1:0] down_rdata;
  logic              down_rbusy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_busy(m0_busy), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_busy(m1_busy), .m1_done(m1_done), .m1_err(m1_err),
    .down_addr(down_addr), .down_wdata(down_wdata), .down_wmask(down_wmask),
    .down_rstrb(down_rstrb), .down_rdata(down_rdata), .down_rbusy(down_rbusy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        req;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rbusy_cyc;   // down_rbusy high for this many cycles starting at ISSUE
    logic [31:0] rdata;
    logic        exp_rstrb;
    logic [3:0]  exp_wmask;
    int          exp_done;    // cycle of mi_done relative to the strobe cycle
    logic [31:0] exp_rdata;
  } txn_t;

  typedef struct {
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic        d0;
    logic        d1;
  } cyc_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    m0_rstrb = 1'b0; m0_wmask = '0;
    m1_rstrb = 1'b0; m1_wmask = '0;
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    logic [31:0] other_rd;
    int          cyc;
    bit          seen, other_done, busy_drop;
    logic        own_done, own_busy;
    other_rd = t.req ? m0_rdata : m1_rdata;
    if (t.req) begin
      m1_rstrb = t.rstrb; m1_wmask = t.wmask; m1_addr = t.addr; m1_wdata = t.wdata;
    end else begin
      m0_rstrb = t.rstrb; m0_wmask = t.wmask; m0_addr = t.addr; m0_wdata = t.wdata;
    end
    check({tag, "_busy_before"}, t.req ? m1_busy : m0_busy, 0);
    step();
    clear_strobes();
    down_rdata = t.rdata;
    down_rbusy = (t.rbusy_cyc > 0);
    check({tag, "_issue_rstrb"}, down_rstrb, t.exp_rstrb);
    check({tag, "_issue_wmask"}, down_wmask, t.exp_wmask);
    check({tag, "_issue_addr"}, down_addr, t.addr);
    if (t.exp_wmask != 4'h0) check({tag, "_issue_wdata"}, down_wdata, t.wdata);
    check({tag, "_busy_issue"}, t.req ? m1_busy : m0_busy, 1);
    cyc = 1; seen = 0; other_done = 0; busy_drop = 0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      down_rbusy = (cyc <= t.rbusy_cyc);
      own_done = t.req ? m1_done : m0_done;
      own_busy = t.req ? m1_busy : m0_busy;
      if (cyc == 2) check({tag, "_strobe_cleared"}, {down_rstrb, down_wmask}, 5'b0);
      if ((t.req ? m0_done : m1_done) == 1'b1) other_done = 1;
      if (!own_done && !own_busy) busy_drop = 1;
      if (own_done) begin
        seen = 1;
        check({tag, "_busy_at_done"}, own_busy, 0);
      end
    end
    down_rbusy = 1'b0;
    check({tag, "_done_cycle"}, seen ? cyc : -1, t.exp_done);
    check({tag, "_busy_held"}, busy_drop, 0);
    check({tag, "_rdata"}, t.req ? m1_rdata : m0_rdata, t.exp_rdata);
    check({tag, "_other_done"}, other_done, 0);
    check({tag, "_other_rdata"}, t.req ? m0_rdata : m1_rdata, other_rd);
    step();
    check({tag, "_done_oneshot"}, t.req ? m1_done : m0_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    txn_t        vec [8];
    txn_t        post_rst;
    cyc_t        exp_b [4];
    int          cyc, extra, first_req, sent0, sent1;
    bit          seen, stray, gotdone;
    logic [31:0] obs_addr [$];
    logic [3:0]  obs_mask [$];
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;

    //           req  rstrb wmask  addr          wdata         rb rdata         erst emask done exp_rdata
    vec[0] = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,        0, 32'hDEAD_BEEF, 1'b1, 4'h0, 3, 32'hDEAD_BEEF};
    vec[1] = '{1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0,        5, 32'h1234_5678, 1'b1, 4'h0, 7, 32'h1234_5678};
    vec[2] = '{1'b0, 1'b0, 4'hF, 32'h0040_0004, 32'hA5A5_A5A5, 0, 32'hFFFF_FFFF, 1'b0, 4'hF, 2, 32'hDEAD_BEEF};
    vec[3] = '{1'b1, 1'b0, 4'h3, 32'h0000_0030, 32'h1122_3344, 0, 32'hFFFF_FFFF, 1'b0, 4'h3, 2, 32'h1234_5678};
    vec[4] = '{1'b0, 1'b1, 4'h0, 32'h0000_0044, 32'h0,        1, 32'hCAFE_F00D, 1'b1, 4'h0, 3, 32'hCAFE_F00D};
    vec[5] = '{1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0,        2, 32'h0BAD_C0DE, 1'b1, 4'h0, 4, 32'h0BAD_C0DE};
    vec[6] = '{1'b1, 1'b1, 4'hC, 32'h0000_0050, 32'h9988_7766, 0, 32'hFFFF_FFFF, 1'b0, 4'hC, 2, 32'h1234_5678};
    vec[7] = '{1'b1, 1'b1, 4'h0, 32'h0000_0054, 32'h0,        0, 32'h7654_3210, 1'b1, 4'h0, 3, 32'h7654_3210};
    post_rst = '{1'b0, 1'b1, 4'h0, 32'h0000_0080, 32'h0,      0, 32'h1357_9BDF, 1'b1, 4'h0, 3, 32'h1357_9BDF};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_b[0] = '{1'b1, 4'h0, 32'h0080_0000, 1'b0, 1'b0};
    exp_b[1] = '{1'b0, 4'h0, 32'h0080_0000, 1'b0, 1'b0};
    exp_b[2] = '{1'b0, 4'hF, 32'h0040_0004, 1'b0, 1'b1};
    exp_b[3] = '{1'b0, 4'h0, 32'h0040_0004, 1'b1, 1'b0};
    first_req = 1;
`else
    exp_b[0] = '{1'b0, 4'hF, 32'h0040_0004, 1'b0, 1'b0};
    exp_b[1] = '{1'b1, 4'h0, 32'h0080_0000, 1'b1, 1'b0};
    exp_b[2] = '{1'b0, 4'h0, 32'h0080_0000, 1'b0, 1'b0};
    exp_b[3] = '{1'b0, 4'h0, 32'h0080_0000, 1'b0, 1'b1};
    first_req = 0;
`endif

    reset_n = 1'b0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    clear_strobes();
    down_rdata = '0; down_rbusy = 1'b0;
    step();
    step();
    check("rst_outputs", {m0_rdata, m1_rdata, down_addr, down_wdata}, 128'h0);
    check("rst_flags", {m0_busy, m1_busy, m0_done, m1_done, m0_err, m1_err, down_rstrb, down_wmask}, 11'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_txn(vec[i], $sformatf("vec%0d", i));

    // Second strobe while busy must be dropped and flagged.
    m0_rstrb = 1'b1; m0_addr = 32'h60; down_rdata = 32'h600D_F00D; down_rbusy = 1'b0;
    step();
    m0_rstrb = 1'b0; m0_wmask = 4'hF; m0_addr = 32'h999; m0_wdata = 32'hBAD;
    down_rbusy = 1'b1;
    check("viol_issue", {down_rstrb, down_addr}, {1'b1, 32'h60});
    cyc = 1; seen = 0; stray = 0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 2) begin
        m0_wmask = '0;
        check("viol_err_set", m0_err, 1);
      end
      down_rbusy = (cyc <= 3);
      if ((|down_wmask) || down_rstrb || down_addr == 32'h999) stray = 1;
      if (m0_done) seen = 1;
    end
    down_rbusy = 1'b0;
    check("viol_done_cycle", seen ? cyc : -1, 5);
    check("viol_rdata", m0_rdata, 32'h600D_F00D);
    check("viol_no_stray", stray, 0);
    step(); step(); step();
    check("viol_err_sticky", m0_err, 1);
    check("viol_m1_err", m1_err, 0);
    check("viol_busy_after", m0_busy, 0);

    // Simultaneous m0 write and m1 read.
    m0_wmask = 4'hF; m0_addr = 32'h0040_0004; m0_wdata = 32'h0102_0304;
    m1_rstrb = 1'b1; m1_addr = 32'h0080_0000;
    down_rbusy = 1'b0; down_rdata = 32'h55AA_55AA;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) clear_strobes();
      check($sformatf("simul_c%0d_rstrb", c + 1), down_rstrb, exp_b[c].rstrb);
      check($sformatf("simul_c%0d_wmask", c + 1), down_wmask, exp_b[c].wmask);
      check($sformatf("simul_c%0d_addr", c + 1), down_addr, exp_b[c].addr);
      check($sformatf("simul_c%0d_done", c + 1), {m0_done, m1_done}, {exp_b[c].d0, exp_b[c].d1});
    end
    step();
    check("simul_m1_rdata", m1_rdata, 32'h55AA_55AA);
    check("simul_idle_busy", {m0_busy, m1_busy}, 2'b00);

    // Reset pulse during WAIT of an m1 read.
    m1_rstrb = 1'b1; m1_addr = 32'h70; down_rdata = 32'hFEED_FACE;
    step();
    m1_rstrb = 1'b0; down_rbusy = 1'b1;
    check("rstwait_issue", {down_rstrb, down_addr}, {1'b1, 32'h70});
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rstwait_rdata", {m0_rdata, m1_rdata}, 64'h0);
    check("rstwait_down", {down_addr, down_wdata, down_rstrb, down_wmask}, 69'h0);
    check("rstwait_flags", {m0_busy, m1_busy, m0_done, m1_done, m0_err, m1_err}, 6'h0);
    gotdone = 0; stray = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) down_rbusy = 1'b0;
      if (m1_done) gotdone = 1;
      if (down_rstrb || (|down_wmask)) stray = 1;
      step();
    end
    check("rstwait_no_m1_done", gotdone, 0);
    check("rstwait_no_stray", stray, 0);
    run_txn(post_rst, "post_rst");

    // Both requesters keep refilling writes; 20 must appear once each, alternating.
    sent0 = 0; sent1 = 0;
    for (int c = 0; c < 100 && obs_addr.size() < 20; c++) begin
      if (!m0_busy && sent0 < 10) begin
        m0_wmask = 4'(sent0 + 1); m0_addr = 32'h1000 + 32'(sent0 * 4); m0_wdata = 32'(sent0); sent0++;
      end else begin
        m0_wmask = '0;
      end
      if (!m1_busy && sent1 < 10) begin
        m1_wmask = 4'(15 - sent1); m1_addr = 32'h2000 + 32'(sent1 * 4); m1_wdata = 32'(sent1); sent1++;
      end else begin
        m1_wmask = '0;
      end
      if (|down_wmask) begin
        obs_addr.push_back(down_addr);
        obs_mask.push_back(down_wmask);
      end
      step();
    end
    clear_strobes();
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (|down_wmask) extra++;
      step();
    end
    check("alt_count", obs_addr.size(), 20);
    check("alt_extra", extra, 0);
    for (int i = 0; i < 20 && i < obs_addr.size(); i++) begin
      if (((i % 2) ^ first_req) == 1) begin
        exp_addr = 32'h2000 + 32'((i / 2) * 4);
        exp_mask = 4'(15 - i / 2);
      end else begin
        exp_addr = 32'h1000 + 32'((i / 2) * 4);
        exp_mask = 4'(i / 2 + 1);
      end
      check($sformatf("alt_txn%0d", i), {obs_addr[i], obs_mask[i]}, {exp_addr, exp_mask});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single system memory bus between the CPU (requester 0) and a second bus master such as a DMA or display-refresh engine (requester 1). It sits between the masters and the address decoder that feeds RAM, SPI flash and IO. Each requester gets its own strobe/busy port. The arbiter captures every single-cycle strobe, serializes transactions onto the downstream port, and honours the downstream `rbusy` stall for multi-cycle reads such as flash.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; wmask width is `DATA_W/8`

- `clk` in 1: system clock
- `reset_n` in 1: synchronous, active-low reset
- `m0_addr`, `m1_addr` in ADDR_W: request address, sampled with strobe
- `m0_wdata`, `m1_wdata` in DATA_W: write data, sampled with strobe
- `m0_wmask`, `m1_wmask` in DATA_W/8: nonzero for one cycle = write strobe
- `m0_rstrb`, `m1_rstrb` in 1: one-cycle read strobe
- `m0_rdata`, `m1_rdata` out DATA_W: registered read data per requester
- `m0_busy`, `m1_busy` out 1: request pending or in flight
- `m0_done`, `m1_done` out 1: one-cycle completion pulse
- `m0_err`, `m1_err` out 1: sticky protocol-violation flag
- `down_addr` out ADDR_W, `down_wdata` out DATA_W, `down_wmask` out DATA_W/8, `down_rstrb` out 1: downstream request
- `down_rdata` in DATA_W, `down_rbusy` in 1: downstream response

## Operation
- Per requester: a capture slot holding addr, wdata, wmask, read/write flag and a valid bit.
  - A strobe with the slot empty loads the slot.
  - A strobe with both rstrb and nonzero wmask is treated as a write.
- A strobe while `mi_busy`=1 is a violation. The strobe is dropped, `mi_err` is set, and the in-flight request is unaffected.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any slot is valid, pick the owner by arbitration and go to ISSUE.
  - ISSUE: drive the owner's slot onto `down_*` for exactly one cycle, with `down_rstrb`=1 for a read or `down_wmask`=slot mask for a write.
    - Write: completes in this cycle. Clear the slot and pulse `mi_done` next cycle.
    - Read: go to WAIT.
  - WAIT: stay while `down_rbusy`=1. On the first WAIT cycle with `down_rbusy`=0:
    - latch `down_rdata` into `mi_rdata`;
    - clear the slot and pulse `mi_done` next cycle.
  - After completion: go to ISSUE directly if the other slot is valid, else IDLE.
- Outside ISSUE, all `down_*` strobe/mask outputs are 0 and `down_addr`/`down_wdata` hold their last values.
- `mi_busy` = slot valid. It is registered, so it is high from the cycle after the strobe until the cycle `mi_done` pulses.
- A requester may strobe again in the same cycle its `mi_done` is high.
- `mi_rdata` holds its value until the next read completion for that requester. Writes do not alter it.
- Reset (`reset_n`=0 at an edge, any state including mid-WAIT): state IDLE, slots cleared, any downstream read abandoned.
  - Reset output values: all `mi_rdata`=0, `mi_busy`=0, `mi_done`=0, `mi_err`=0, `down_rstrb`=0, `down_wmask`=0, `down_addr`=0, `down_wdata`=0.

## Timing
- Strobe in cycle T is captured at the end of T. ISSUE is cycle T+1 if the bus is free.
- Write: `mi_done` in T+2.
- Read with zero-wait target (`down_rbusy`=0 at T+2): `mi_rdata` valid and `mi_done` in T+3, `mi_busy` low in T+3.
- Each downstream `rbusy` cycle adds one cycle.
- Downstream contract: `down_rbusy` must be asserted by the cycle after `down_rstrb` for a stalled read.
- Back-to-back throughput: one transaction per 2 cycles for reads (ISSUE+WAIT), one per cycle for writes when both slots are loaded.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both slots are valid, grant the requester not granted most recently. The last-grant register resets to requester 1, so requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 always wins ties. No last-grant register.

## Test plan
- Single m0 read of 0x00000010 with downstream returning 0xDEADBEEF and `down_rbusy`=0 -> `down_rstrb` at T+1 with `down_addr`=0x10, `m0_rdata`=0xDEADBEEF and `m0_done` at T+3, `m1_*` untouched.
- m1 read with `down_rbusy` held high 5 cycles after ISSUE -> `m1_busy` high through WAIT, `m1_done` exactly 6 cycles after ISSUE, data 0x12345678 latched.
- Simultaneous m0 write (wmask 0xF, 0x00400004) and m1 read (0x00800000):
  - without the macro: m0 issued first at T+1, m1 at T+2;
  - with the macro, after a prior m0 grant: m1 first.
- m0 strobes again while `m0_busy`=1 -> second request never reaches `down_*`, `m0_err`=1 and sticky, first request completes normally.
- `reset_n` low for one cycle during WAIT of an m1 read -> next cycle all outputs at reset values, no `m1_done`, and a new m0 read completes normally.
- Alternating m0/m1 writes, both slots continuously refilled, 20 transactions -> every transaction appears once on `down_wmask` in grant order, none lost or duplicated.
